fifo_wr_arbiter: RTL and testbench

//   Round-robin arbiter sharing the single write port of the 16x8 FIFO between NREQ

---
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of the 16x8 FIFO.
// Bursts of up to BURST_MAX words per grant, stalls on fifo_full.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int BURST_MAX = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               fifo_full,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    ack,
    output logic               fifo_we,
    output logic [DW-1:0]      fifo_wr_data,
    output logic               busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(BURST_MAX) + 1;

    localparam logic [CW-1:0]   CNT_LAST = CW'(BURST_MAX - 1);
    localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE      = NREQ'(1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    logic            win_vld;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   scan;
    logic            own_req;
    logic            own_ack;
    logic            release_c;
    logic [DW-1:0]   own_data;

    // Scan starts just past the last owner, so it ranks lowest.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        scan    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan = IW'((int'(last_q) + k) % NREQ);
            if (!win_vld && req[scan]) begin
                win_vld = 1'b1;
                win_idx = scan;
            end
        end
    end

    always_comb begin
        own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                own_data = own_data | req_data[i*DW +: DW];
            end
        end
    end

    assign ack = (reset || fifo_full) ? '0 : (grant_q & req);

    assign own_req   = |(grant_q & req);
    assign own_ack   = |ack;
    assign release_c = !own_req || (own_ack && (cnt_q == CNT_LAST));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = BUSY;
                    grant_d = ONE << win_idx;
                    last_d  = win_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (release_c) begin
                    cnt_d = '0;
                    if (win_vld) begin
                        grant_d = ONE << win_idx;
                        last_d  = win_idx;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end else if (own_ack) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant        = grant_q;
    assign fifo_we      = own_ack;
    assign fifo_wr_data = own_data;
    assign busy         = (state_q == BUSY);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: scenario tasks plus random traffic
// against an owner/burst-count reference model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int BM   = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               fifo_full;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    ack;
    logic               fifo_we;
    logic [DW-1:0]      fifo_wr_data;
    logic               busy;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BM)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .fifo_full    (fifo_full),
        .grant        (grant),
        .ack          (ack),
        .fifo_we      (fifo_we),
        .fifo_wr_data (fifo_wr_data),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    int left[NREQ];
    int en[NREQ];
    int seq[NREQ];
    bit full;

    int m_owner;
    int m_last;
    int m_cnt;

    logic [DW-1:0]   wlog[$];
    logic [NREQ-1:0] wgnt[$];

    function automatic logic [DW-1:0] word(int i, int s);
        return DW'(((i + 10) << 4) | ((s + 1) & 15));
    endfunction

    function automatic bit rq(int i);
        return (left[i] > 0) && (en[i] != 0);
    endfunction

    // One clock: drive, check at mid-cycle, advance model and producers.
    task automatic cyc();
        logic [NREQ-1:0]    r;
        logic [NREQ*DW-1:0] d;
        logic [NREQ-1:0]    eg;
        logic [NREQ-1:0]    ea;
        logic [DW-1:0]      ed;
        bit                 a;
        bit                 eb;
        int                 win;
        int                 ao;
        int                 j;
        r = '0;
        d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rq(i)) r = r | (NREQ'(1) << i);
            d[i*DW +: DW] = word(i, seq[i]);
        end
        req       = r;
        req_data  = d;
        fifo_full = full;
        #4;
        eg = (m_owner < 0) ? '0 : (NREQ'(1) << m_owner);
        a  = (m_owner >= 0) && rq(m_owner) && !full && !reset;
        ea = a ? (NREQ'(1) << m_owner) : '0;
        ed = (m_owner >= 0) ? word(m_owner, seq[m_owner]) : '0;
        eb = (m_owner >= 0);
        total++;
        if (grant !== eg || ack !== ea || fifo_we !== a ||
            fifo_wr_data !== ed || busy !== eb) begin
            bad++;
            $display("FAIL cycle t=%0t grant=%b want %b ack=%b want %b we=%b want %b data=%h want %h busy=%b want %b",
                     $time, grant, eg, ack, ea, fifo_we, a,
                     fifo_wr_data, ed, busy, eb);
        end
        if (fifo_we === 1'b1) begin
            wlog.push_back(fifo_wr_data);
            wgnt.push_back(grant);
        end
        ao  = a ? m_owner : -1;
        win = -1;
        for (int k = 1; k <= NREQ; k++) begin
            j = (m_last + k) % NREQ;
            if (win < 0 && rq(j)) win = j;
        end
        if (reset) begin
            m_owner = -1;
            m_last  = NREQ - 1;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            if (win >= 0) begin
                m_owner = win;
                m_last  = win;
                m_cnt   = 0;
            end
        end else if (!rq(m_owner) || (a && m_cnt == BM - 1)) begin
            m_cnt = 0;
            if (win >= 0) begin
                m_owner = win;
                m_last  = win;
            end else begin
                m_owner = -1;
            end
        end else if (a) begin
            m_cnt++;
        end
        @(posedge clock);
        #1;
        if (ao >= 0) begin
            seq[ao]++;
            left[ao]--;
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 0;
            en[i]   = 0;
            seq[i]  = 0;
        end
        full  = 1'b0;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        wlog.delete();
        wgnt.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 100;
            en[i]   = 1;
            seq[i]  = 0;
        end
        full  = 1'b0;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL reset_first_grant got %b want 0001", grant);
        end
    endtask

    task automatic test_single();
        do_reset();
        en[0]   = 1;
        left[0] = 3;
        cyc();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL single_latency got %b want 0001", grant);
        end
        for (int n = 0; n < 9; n++) cyc();
        total++;
        if (wlog.size() != 3 || wlog[0] !== 8'hA1 ||
            wlog[1] !== 8'hA2 || wlog[2] !== 8'hA3) begin
            bad++;
            $display("FAIL single_writes got %0d words want A1 A2 A3",
                     wlog.size());
        end
        total++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_release grant=%b busy=%b want 0000 0",
                     grant, busy);
        end
    endtask

    task automatic test_rotation();
        int err;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            en[i]   = 1;
            left[i] = 1000;
        end
        cyc();
        for (int n = 0; n < 20; n++) cyc();
        total++;
        if (wlog.size() != 20) begin
            bad++;
            $display("FAIL rotation_no_gap got %0d writes want 20",
                     wlog.size());
        end
        err = -1;
        for (int k = 0; k < 17 && k < wgnt.size(); k++) begin
            if (err < 0 && wgnt[k] !== (NREQ'(1) << ((k / 4) % 4))) err = k;
        end
        total++;
        if (err >= 0 || wgnt.size() < 17) begin
            bad++;
            $display("FAIL rotation_order at write %0d of %0d", err,
                     wgnt.size());
        end
    endtask

    task automatic test_full();
        int n;
        logic [DW-1:0] exp_w[5];
        exp_w = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1};
        do_reset();
        en[0]   = 1;
        en[1]   = 1;
        left[0] = 20;
        left[1] = 20;
        n = 0;
        while (seq[0] < 2 && n < 10) begin
            cyc();
            n++;
        end
        full = 1'b1;
        for (int k = 0; k < 5; k++) cyc();
        total++;
        if (wlog.size() != 2 || grant !== 4'b0001) begin
            bad++;
            $display("FAIL full_stall writes=%0d grant=%b want 2 0001",
                     wlog.size(), grant);
        end
        full = 1'b0;
        for (int k = 0; k < 6; k++) cyc();
        for (int k = 0; k < 5; k++) begin
            total++;
            if (k >= wlog.size() || wlog[k] !== exp_w[k]) begin
                bad++;
                $display("FAIL full_resume word %0d want %h", k, exp_w[k]);
            end
        end
    endtask

    task automatic test_drop();
        int n;
        do_reset();
        en[0]   = 1;
        en[2]   = 1;
        left[0] = 1;
        left[2] = 2;
        n = 0;
        while (seq[2] < 1 && n < 10) begin
            cyc();
            n++;
        end
        en[1]   = 1;
        left[0] = 3;
        left[1] = 3;
        for (int k = 0; k < 6; k++) cyc();
        total++;
        if (wlog.size() < 4 || wlog[0] !== 8'hA1 || wlog[1] !== 8'hC1 ||
            wlog[2] !== 8'hC2 || wlog[3] !== 8'hA2) begin
            bad++;
            $display("FAIL drop_order got %0d words want A1 C1 C2 A2",
                     wlog.size());
        end
        total++;
        if (wgnt.size() < 4 || wgnt[1] !== 4'b0100 || wgnt[3] !== 4'b0001) begin
            bad++;
            $display("FAIL drop_grants want 0100 then 0001");
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        en[1]   = 1;
        left[1] = 10;
        n = 0;
        while (seq[1] < 2 && n < 10) begin
            cyc();
            n++;
        end
        en[0]   = 1;
        left[0] = 10;
        reset   = 1'b1;
        cyc();
        reset   = 1'b0;
        total++;
        if (grant !== 4'b0000 || busy !== 1'b0 || wlog.size() != 2) begin
            bad++;
            $display("FAIL reset_mid grant=%b busy=%b writes=%0d want 0000 0 2",
                     grant, busy, wlog.size());
        end
        cyc();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL reset_mid_regrant got %b want 0001", grant);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (left[i] == 0 && $urandom_range(2) == 0)
                    left[i] = 1 + int'($urandom_range(5));
                en[i] = ($urandom_range(7) != 0) ? 1 : 0;
            end
            full = ($urandom_range(3) == 0);
            cyc();
        end
        full = 1'b0;
    endtask

    initial begin
        m_owner   = -1;
        m_last    = NREQ - 1;
        m_cnt     = 0;
        reset     = 1'b1;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        full      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 0;
            en[i]   = 0;
            seq[i]  = 0;
        end
        @(posedge clock);
        #1;
        test_reset();
        test_single();
        test_rotation();
        test_full();
        test_drop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
